dmem_access_ctrl: RTL

Sequencing controller between the execute stage and the data-memory port. It accepts a decoded load or store with its funct3, address and store data, and drives a request/acknowledge transaction to data memory. It stalls the pipeline while the transaction is outstanding, then returns sign- or zero-extended load data with a one-cycle `dm_valid_o` pulse. That pulse is the signal the control unit consumes to suppress re-issue of the same load and to enable register write-back.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_access_ctrl_if.sv | 25 ++
 rtl/dmem_lane_align.sv | 53 +++++
 rtl/dmem_access_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access controller.
// Holds the FSM state type, funct3 encodings and the alignment rule.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } dmem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] MASK_W = 4'b1111;

  // Encodings 011/110/111 fall into the word case and need word alignment.
  function automatic logic is_misaligned(input logic [2:0] fun3, input logic [1:0] addr_lo);
    case (fun3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return addr_lo[0];
      default: return (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request/acknowledge bus between the access controller and data memory.
// The controller uses the master modport and the memory uses the slave modport.
interface dmem_access_ctrl_if #(
  parameter int XLEN = 32
);

  logic            mem_req_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [3:0]      mem_wmask_o;
  logic            mem_ack_i;
  logic [XLEN-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output mem_ack_i, mem_rdata_i
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store mask/data replication and load extract/extend.
// Purely combinational; the store and load paths are independent.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      st_fun3,
  input  logic [1:0]      st_addr_lo,
  input  logic [XLEN-1:0] st_wdata,
  output logic [3:0]      st_wmask,
  output logic [XLEN-1:0] st_wdata_lanes,
  output logic            st_misaligned,
  input  logic [2:0]      ld_fun3,
  input  logic [1:0]      ld_addr_lo,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] ld_shifted;

  assign st_misaligned = is_misaligned(st_fun3, st_addr_lo);
  assign ld_shifted    = ld_rdata >> {ld_addr_lo, 3'b000};

  always_comb begin
    st_wmask       = MASK_W;
    st_wdata_lanes = st_wdata;
    case (st_fun3[1:0])
      2'b00: begin
        st_wmask       = 4'b0001 << st_addr_lo;
        st_wdata_lanes = {4{st_wdata[7:0]}};
      end
      2'b01: begin
        st_wmask       = 4'b0011 << st_addr_lo;
        st_wdata_lanes = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Word accesses are always aligned, so the shifted word equals the raw word.
  always_comb begin
    ld_data = ld_shifted;
    case (ld_fun3)
      F3_LB:   ld_data = {{(XLEN-8){ld_shifted[7]}}, ld_shifted[7:0]};
      F3_LH:   ld_data = {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
      F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, ld_shifted[7:0]};
      F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, ld_shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences one load/store from execute into a req/ack data-memory transaction,
// stalling the pipeline until it completes and then pulsing valid or error.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int FUNCTION3 = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 store_i,
  input  logic [FUNCTION3-1:0] fun3_i,
  input  logic [XLEN-1:0]      addr_i,
  input  logic [XLEN-1:0]      wdata_i,
  dmem_access_ctrl_if.master   mem,
  output logic                 stall_o,
  output logic                 dm_valid_o,
  output logic [XLEN-1:0]      load_data_o,
  output logic                 err_o
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  dmem_state_t     state, state_next;
  logic [7:0]      cnt;
  logic [2:0]      fun3_q;
  logic [1:0]      addr_lo_q;
  logic            is_load_q;
  logic            err_q;

  logic            start;
  logic            start_ok;
  logic            start_bad;
  logic            ack_take;
  logic            timeout_hit;
  logic [3:0]      st_wmask;
  logic [XLEN-1:0] st_wdata_lanes;
  logic            st_misaligned;
  logic [XLEN-1:0] ld_data;

  assign start = load_i | store_i;

  dmem_lane_align #(.XLEN(XLEN)) u_lane_align (
    .st_fun3        (fun3_i[2:0]),
    .st_addr_lo     (addr_i[1:0]),
    .st_wdata       (wdata_i),
    .st_wmask       (st_wmask),
    .st_wdata_lanes (st_wdata_lanes),
    .st_misaligned  (st_misaligned),
    .ld_fun3        (fun3_q),
    .ld_addr_lo     (addr_lo_q),
    .ld_rdata       (mem.mem_rdata_i),
    .ld_data        (ld_data)
  );

  // An ack on the final allowed cycle takes priority over the timeout.
  always_comb begin
    state_next  = state;
    start_ok    = 1'b0;
    start_bad   = 1'b0;
    ack_take    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = st_misaligned ? DONE : ACCESS;
          start_ok   = !st_misaligned;
          start_bad  = st_misaligned;
        end
      end
      ACCESS: begin
        if (mem.mem_ack_i) begin
          ack_take   = 1'b1;
          state_next = DONE;
        end else if (cnt == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign stall_o    = rst_n && (((state == IDLE) && start) || (state == ACCESS));
  assign dm_valid_o = (state == DONE) && is_load_q && !err_q;
  assign err_o      = (state == DONE) && err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= 8'd0;
      fun3_q          <= 3'd0;
      addr_lo_q       <= 2'd0;
      is_load_q       <= 1'b0;
      err_q           <= 1'b0;
      load_data_o     <= '0;
      mem.mem_req_o   <= 1'b0;
      mem.mem_we_o    <= 1'b0;
      mem.mem_addr_o  <= '0;
      mem.mem_wdata_o <= '0;
      mem.mem_wmask_o <= 4'd0;
    end else begin
      state <= state_next;
      if (state == ACCESS) begin
        cnt <= cnt + 8'd1;
      end
      if (start_ok) begin
        cnt             <= 8'd0;
        fun3_q          <= fun3_i[2:0];
        addr_lo_q       <= addr_i[1:0];
        is_load_q       <= load_i;
        err_q           <= 1'b0;
        mem.mem_req_o   <= 1'b1;
        mem.mem_we_o    <= !load_i;
        mem.mem_addr_o  <= {addr_i[XLEN-1:2], 2'b00};
        mem.mem_wdata_o <= st_wdata_lanes;
        mem.mem_wmask_o <= load_i ? 4'd0 : st_wmask;
      end
      if (start_bad) begin
        is_load_q <= load_i;
        err_q     <= 1'b1;
      end
      if (ack_take) begin
        mem.mem_req_o <= 1'b0;
        load_data_o   <= ld_data;
      end
      if (timeout_hit) begin
        mem.mem_req_o <= 1'b0;
        err_q         <= 1'b1;
      end
    end
  end

endmodule
